// File: rtl/rangefinder_sopc_leds_port.sv
// Avalon-MM output PIO for the rangefinder front-panel LEDs. It provides a data register,
// atomic set/clear aliases and a per-bit blink mask driven by a programmable period.
module rangefinder_sopc_leds_port #(
  parameter int unsigned             WIDTH       = 8,
  parameter int unsigned             PERIOD_W    = 24,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [WIDTH-1:0]    out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic                wr;
  logic [WIDTH-1:0]    wrBits;
  logic [PERIOD_W-1:0] wrPeriod;

  logic [WIDTH-1:0]    data_q,     data_d;
  logic [WIDTH-1:0]    mask_q,     mask_d;
  logic [PERIOD_W-1:0] period_q,   period_d;
  logic [PERIOD_W-1:0] cnt_q,      cnt_d;
  logic                phase_q,    phase_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [WIDTH-1:0]    outPort_q,  outPort_d;

  // Only the low register-width bits of writedata carry meaning.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr       = chipselect & ~write_n;
  assign wrBits   = writedata[WIDTH-1:0];
  assign wrPeriod = writedata[PERIOD_W-1:0];

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_d   = wrBits;
        ADDR_MASK:     mask_d   = wrBits;
        ADDR_PERIOD:   period_d = wrPeriod;
        ADDR_OUTSET:   data_d   = data_q | wrBits;
        ADDR_OUTCLEAR: data_d   = data_q & ~wrBits;
        default:       ;
      endcase
    end
  end

  // A PERIOD write restarts the blink cycle and wins over a terminal-count toggle.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr && (address == ADDR_PERIOD)) begin
      cnt_d   = wrPeriod;
      phase_d = 1'b0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q <= PERIOD_W'(1)) begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - PERIOD_W'(1);
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d = 32'(data_q);
      ADDR_MASK:   readdata_d = 32'(mask_q);
      ADDR_PERIOD: readdata_d = 32'(period_q);
      ADDR_STATUS: readdata_d = {31'd0, phase_q};
      default:     readdata_d = '0;
    endcase
  end

  assign outPort_d = data_q & ~(mask_q & {WIDTH{phase_q}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
      outPort_q  <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
      outPort_q  <= outPort_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = outPort_q;

endmodule

// File: doc/rangefinder_sopc_leds_port.md
Name: rangefinder_sopc_leds_port

Overview:
- Avalon-MM slave output PIO that drives front-panel LEDs and indicators in the rangefinder SOPC. It is the write-side counterpart of the buttons input port.
- The CPU writes a data register, either directly or through atomic set/clear aliases.
- A per-bit blink mask, driven by a programmable period counter, makes selected outputs flash with no CPU involvement.
- Reads return registered register contents, using the same one-cycle read latency as the input PIO.

Parameters:
- WIDTH, 8, number of output bits on out_port.
- PERIOD_W, 24, width of the blink period register and counter.
- RESET_VALUE, 0, value loaded into the data register on reset.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register select.
- chipselect  in  1  slave select; qualifies writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  registered read data; unused upper bits are 0.
- out_port  out  WIDTH  registered LED drive.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. All writes take effect on the clock edge where wr=1. There are no wait states.
- Register map:
  - 0 DATA (R/W): data[WIDTH-1:0].
  - 1 BLINK_MASK (R/W): mask[WIDTH-1:0].
  - 2 PERIOD (R/W): period[PERIOD_W-1:0].
  - 3 STATUS (RO): bit0 = phase; all other bits 0. Writes are ignored.
  - 4 OUTSET (WO): data <= data | writedata[WIDTH-1:0]. Reads return 0.
  - 5 OUTCLEAR (WO): data <= data & ~writedata[WIDTH-1:0]. Reads return 0.
  - 6, 7: reads return 0; writes are ignored.
- Read path:
  - readdata is registered every cycle from the address mux, regardless of chipselect.
  - Latency is 1 cycle: a value is visible the cycle after address is presented.
  - If a read hits a register written in the same cycle, it returns the pre-write value. The new value appears one cycle later.
- Blink engine (counter cnt[PERIOD_W-1:0], phase bit):
  - When period==0: cnt and phase are held at 0, so blinking is disabled.
  - When period!=0: each cycle, if cnt<=1 then toggle phase and set cnt<=period; else cnt<=cnt-1.
  - Result: phase toggles every `period` cycles, giving a full blink cycle of 2*period cycles.
  - A write to PERIOD sets period<=new value, cnt<=new value, and phase<=0 on the same edge. This write overrides any terminal-count toggle in that cycle.
  - A write to PERIOD with value 0 forces cnt<=0 and phase<=0.
- Output:
  - out_port <= data & ~(mask & {WIDTH{phase}}), registered.
  - out_port therefore lags a DATA, MASK or phase change by exactly 1 cycle.
  - Masked bits read as off during phase=1. Unmasked bits follow data.
- Simultaneous events: only one register can be written per cycle. A blink toggle and a DATA, MASK, OUTSET or OUTCLEAR write in the same cycle are independent, and both take effect.
- Reset values (asynchronous, immediate, including mid-blink):
  - data=RESET_VALUE; mask=0; period=0; cnt=0; phase=0.
  - readdata=0; out_port=RESET_VALUE.
  - After deassertion, logic resumes on the next clock edge, with blinking disabled until PERIOD is written.

Test Plan:
- Reset then readback: hold reset, then release. Expect out_port=0x00 and readdata=0. Read addresses 0–7; all return 0 one cycle after each address.
- Set/clear aliases: write DATA=0x0F, then OUTSET 0x30, then OUTCLEAR 0x05. Readback of DATA gives 0x3A. out_port=0x3A one cycle after the last write. Reads of addresses 4 and 5 return 0.
- Blink timing: DATA=0xFF, MASK=0x81, PERIOD=4. out_port alternates 0xFF and 0x7E, with each level lasting exactly 4 cycles. STATUS bit0 tracks phase with 1-cycle read latency.
- Period rewrite at terminal count: write PERIOD=3 on the exact cycle cnt==1. Expect no toggle, phase=0, and the next toggle 3 cycles later. Then write PERIOD=0: phase is held at 0 and out_port=DATA permanently.
- Reset mid-operation: assert reset while phase=1 with MASK=0xFF. out_port goes to RESET_VALUE immediately, without waiting for a clock edge. After release, out_port stays at RESET_VALUE and never blinks without new writes.
- Write qualification: assert write_n=0 with chipselect=0, and separately write to address 3 and address 7. Expect no register change, with readback confirming the prior values.
